// File: rtl/mem_port_arbiter_if.sv
// Bundle between the memory port arbiter, its two requesters (CPU, debug) and the memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          dbg_req;
  logic          dbg_we;
  logic          dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          locked;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_we, mem_wdata,
    output locked
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_we, mem_wdata,
    input  locked
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between CPU (priority) and debug port, with starvation bound and lock.
// Grant is combinational (0 cycles); read data returns 1 cycle after grant; refused requester simply holds.
module mem_port_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {ARB, LOCK} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_DBG} rd_owner_t;

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  rd_owner_t     rd_owner_q, rd_owner_d;

  logic          cpu_win, dbg_win;
  logic          cpu_gnt, dbg_gnt;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          mem_we_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      wait_cnt_q <= 4'd0;
      rd_owner_q <= RD_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (state_q == LOCK) begin
      dbg_win = bus.dbg_req;
    end else if (bus.cpu_req && bus.dbg_req) begin
      dbg_win = (wait_cnt_q >= 4'(MAX_WAIT));
      cpu_win = !dbg_win;
    end else begin
      cpu_win = bus.cpu_req;
      dbg_win = bus.dbg_req;
    end
  end

  // Combinational grants are forced low while reset is held so nothing reaches memory.
  assign cpu_gnt = cpu_win & rst;
  assign dbg_gnt = dbg_win & rst;

  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    if (cpu_gnt) begin
      mem_addr_d  = bus.cpu_addr;
      mem_wdata_d = bus.cpu_wdata;
      mem_we_d    = bus.cpu_we;
    end else if (dbg_gnt) begin
      mem_addr_d  = bus.dbg_addr;
      mem_wdata_d = bus.dbg_wdata;
      mem_we_d    = bus.dbg_we;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rd_owner_d = RD_NONE;

    if (!bus.dbg_req || dbg_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != 4'hF) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    case (state_q)
      ARB:     if (dbg_gnt && bus.dbg_lock) state_d = LOCK;
      LOCK:    if (!bus.dbg_lock)           state_d = ARB;
      default: state_d = ARB;
    endcase

    if (cpu_gnt && !bus.cpu_we) begin
      rd_owner_d = RD_CPU;
    end else if (dbg_gnt && !bus.dbg_we) begin
      rd_owner_d = RD_DBG;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.mem_addr   = mem_addr_d;
  assign bus.mem_wdata  = mem_wdata_d;
  assign bus.mem_we     = mem_we_d;
  assign bus.locked     = (state_q == LOCK);
  assign bus.cpu_rvalid = (rd_owner_q == RD_CPU);
  assign bus.dbg_rvalid = (rd_owner_q == RD_DBG);
  assign bus.cpu_rdata  = (rd_owner_q == RD_CPU) ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = (rd_owner_q == RD_DBG) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural one-cycle-latency memory.
// Inputs change at the falling edge; outputs are sampled 1 time unit later or 1 unit after a rising edge.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.AW(9), .DW(32)) bus ();

  mem_port_arbiter #(.AW(9), .DW(32), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_arr [0:511];
  always @(posedge clk) begin
    if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem_arr[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b0;  bus.cpu_addr = 9'h000; bus.cpu_wdata = 32'h0;
    bus.dbg_req = 1'b1;  bus.dbg_we = 1'b1;  bus.dbg_lock = 1'b0;
    bus.dbg_addr = 9'h1FF; bus.dbg_wdata = 32'hFFFF_FFFF;

    // Reset held with both requesting
    repeat (2) @(negedge clk);
    #1;
    check("rst_cpu_gnt",    bus.cpu_gnt, 0);
    check("rst_dbg_gnt",    bus.dbg_gnt, 0);
    check("rst_mem_we",     bus.mem_we, 0);
    check("rst_mem_addr",   bus.mem_addr, 0);
    check("rst_locked",     bus.locked, 0);
    check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    check("rst_dbg_rvalid", bus.dbg_rvalid, 0);
    check("rst_cpu_rdata",  bus.cpu_rdata, 0);

    // Release: CPU wins the same cycle
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_cpu_gnt", bus.cpu_gnt, 1);
    check("rel_dbg_gnt", bus.dbg_gnt, 0);
    check("rel_mem_we",  bus.mem_we, 0);

    // Debug alone writes DEADBEEF to 0x010
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.dbg_addr = 9'h010; bus.dbg_wdata = 32'hDEAD_BEEF; bus.dbg_we = 1'b1;
    #1;
    check("pre_cpu_rvalid", bus.cpu_rvalid, 1);
    check("pre_dbg_gnt",    bus.dbg_gnt, 1);
    check("pre_mem_we",     bus.mem_we, 1);
    check("pre_mem_addr",   bus.mem_addr, 9'h010);

    // CPU read alone
    @(negedge clk);
    bus.dbg_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h010;
    #1;
    check("rd_cpu_gnt",    bus.cpu_gnt, 1);
    check("rd_mem_addr",   bus.mem_addr, 9'h010);
    check("rd_mem_we",     bus.mem_we, 0);
    check("wr_no_rvalid",  bus.dbg_rvalid, 0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    check("rd_cpu_rvalid", bus.cpu_rvalid, 1);
    check("rd_cpu_rdata",  bus.cpu_rdata, 32'hDEAD_BEEF);
    check("rd_dbg_rvalid", bus.dbg_rvalid, 0);
    check("rd_dbg_rdata",  bus.dbg_rdata, 0);

    // Starvation bound: debug wins on cycles 4 and 9
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_addr = 9'h010;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 9'h010;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      check($sformatf("starve_cpu_gnt_%0d", i), bus.cpu_gnt, (i == 4 || i == 9) ? 0 : 1);
      check($sformatf("starve_dbg_gnt_%0d", i), bus.dbg_gnt, (i == 4 || i == 9) ? 1 : 0);
    end

    // Lock request without debug request has no effect
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0; bus.dbg_lock = 1'b1;
    @(negedge clk);
    #1;
    check("lock_noreq_locked", bus.locked, 0);

    // Locked burst of three writes
    @(negedge clk);
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_lock = 1'b1;
    bus.dbg_addr = 9'h020; bus.dbg_wdata = 32'h1;
    #1;
    check("burst0_dbg_gnt", bus.dbg_gnt, 1);
    check("burst0_locked",  bus.locked, 0);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h020;
    bus.dbg_addr = 9'h021; bus.dbg_wdata = 32'h2;
    #1;
    check("burst1_locked",  bus.locked, 1);
    check("burst1_cpu_gnt", bus.cpu_gnt, 0);
    check("burst1_dbg_gnt", bus.dbg_gnt, 1);
    @(negedge clk);
    bus.dbg_addr = 9'h022; bus.dbg_wdata = 32'h3; bus.dbg_lock = 1'b0;
    #1;
    check("burst2_locked",  bus.locked, 1);
    check("burst2_cpu_gnt", bus.cpu_gnt, 0);
    check("burst2_dbg_gnt", bus.dbg_gnt, 1);
    check("burst2_mem_we",  bus.mem_we, 1);
    @(negedge clk);
    bus.dbg_req = 1'b0;
    #1;
    check("unlock_locked",  bus.locked, 0);
    check("unlock_cpu_gnt", bus.cpu_gnt, 1);
    @(negedge clk);
    bus.cpu_addr = 9'h021;
    #1;
    check("rb0_rdata", bus.cpu_rdata, 32'h1);
    @(negedge clk);
    bus.cpu_addr = 9'h022;
    #1;
    check("rb1_rdata", bus.cpu_rdata, 32'h2);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    check("rb2_rdata", bus.cpu_rdata, 32'h3);

    // Write isolation
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 9'h030; bus.cpu_wdata = 32'hA5A5_A5A5;
    #1;
    check("wr_cpu_gnt",   bus.cpu_gnt, 1);
    check("wr_mem_we",    bus.mem_we, 1);
    check("wr_mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    #1;
    check("idle_mem_we",     bus.mem_we, 0);
    check("idle_mem_addr",   bus.mem_addr, 0);
    check("idle_mem_wdata",  bus.mem_wdata, 0);
    check("idle_cpu_rvalid", bus.cpu_rvalid, 0);
    check("idle_dbg_rvalid", bus.dbg_rvalid, 0);

    // Locked debug read, then reset before the data is consumed
    @(negedge clk);
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_lock = 1'b1; bus.dbg_addr = 9'h030;
    #1;
    check("mid_dbg_gnt", bus.dbg_gnt, 1);
    @(posedge clk);
    #1;
    check("mid_locked",     bus.locked, 1);
    check("mid_dbg_rvalid", bus.dbg_rvalid, 1);
    check("mid_dbg_rdata",  bus.dbg_rdata, 32'hA5A5_A5A5);
    rst = 1'b0;
    bus.dbg_req = 1'b0; bus.dbg_lock = 1'b0;
    #1;
    check("midrst_dbg_rvalid", bus.dbg_rvalid, 0);
    check("midrst_dbg_rdata",  bus.dbg_rdata, 0);
    check("midrst_locked",     bus.locked, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h030;
    #1;
    check("post_cpu_gnt",    bus.cpu_gnt, 1);
    check("post_locked",     bus.locked, 0);
    check("post_dbg_rvalid", bus.dbg_rvalid, 0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    check("post2_dbg_rvalid", bus.dbg_rvalid, 0);
    check("post2_cpu_rvalid", bus.cpu_rvalid, 1);
    check("post2_locked",     bus.locked, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory (`Mem`, synchronous read, one-cycle latency) between the multi-cycle CPU datapath and a debug/loader port driven from the board switches and buttons. Per-cycle arbitration gives the CPU priority, with a starvation bound and a locked-burst mode for the debug port. Sits between the CPU's IorD address mux / B register and `Mem`, replacing their direct connection.

## Interface
- `AW`, default 9: memory word-address width (matches the CPU's PC/address width).
- `DW`, default 32: data width.
- `MAX_WAIT`, default 4: consecutive cycles the debug port may be refused before it wins over the CPU; range 1..15.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_req`, `cpu_we`  in  1  CPU access request / write enable.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_gnt`  out  1  CPU access issued this cycle.
- `cpu_rvalid`  out  1  CPU read data valid.
- `cpu_rdata`  out  DW  CPU read data.
- `dbg_req`, `dbg_we`, `dbg_lock`  in  1  debug request / write enable / hold memory for a burst.
- `dbg_addr`  in  AW; `dbg_wdata`  in  DW.
- `dbg_gnt`, `dbg_rvalid`  out  1; `dbg_rdata`  out  DW.
- `mem_addr`  out  AW; `mem_we`  out  1; `mem_wdata`  out  DW  to memory.
- `mem_rdata`  in  DW  memory read data, valid the cycle after the address.
- `locked`  out  1  debug burst owns memory (CPU stall indicator).

## Operation
- States: ARB (normal arbitration), LOCK (debug owns memory).
- ARB winner each cycle: only one requester → it wins. Both request → CPU wins unless `wait_cnt >= MAX_WAIT`, then debug wins.
- `wait_cnt` (4 bits): +1 on each cycle `dbg_req`=1 and `dbg_gnt`=0, saturates at 15; cleared when `dbg_gnt`=1 or `dbg_req`=0.
- ARB → LOCK on edge after a cycle with `dbg_gnt`=1 and `dbg_lock`=1.
- LOCK: only debug can be granted; `cpu_gnt`=0 regardless of `cpu_req`; `locked`=1. LOCK → ARB on edge after any cycle with `dbg_lock`=0 (grant in that cycle still honoured if `dbg_req`=1).
- Grants are combinational from current req/state; winner's addr/we/wdata drive `mem_*` in the same cycle. No winner: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Requester holds req/we/addr/wdata stable until it sees gnt; one access per gnt cycle; back-to-back grants allowed.
- Read return: registered tag `rd_owner` ∈ {none, cpu, dbg} captured from the granted read; next cycle the matching `x_rvalid`=1 and `x_rdata` = `mem_rdata`. Non-owner rdata = 0. Writes produce no rvalid.
- `mem_we` never asserted without a grant.

## Timing
- Reset (async, `rst`=0): state ARB, `wait_cnt`=0, `rd_owner`=none; `cpu_rvalid`=`dbg_rvalid`=0, rdata outputs 0, `locked`=0. Grants and `mem_*` are 0 while in reset.
- Grant latency: 0 cycles from req when uncontested; read data latency 1 cycle after gnt.
- Reset asserted mid-read: pending rvalid dropped, not delivered after release.
- Reset asserted during LOCK: returns to ARB; debug must re-lock.
- `dbg_lock` high with `dbg_req` low in ARB: no effect (lock entry requires a grant).
- Simultaneous CPU and debug requests with `wait_cnt` = MAX_WAIT exactly: debug wins; counter clears next edge.

## Test plan
- Reset: hold `rst`=0 with both reqs high → all grants, rvalid, `mem_we`, `locked` = 0; release → CPU granted same cycle.
- CPU read alone: `cpu_req`=1, `cpu_addr`=9'h010, memory preloaded 32'hDEADBEEF → `cpu_gnt`=1, `mem_addr`=9'h010; next cycle `cpu_rvalid`=1, `cpu_rdata`=32'hDEADBEEF, `dbg_rvalid`=0.
- Starvation bound (MAX_WAIT=4): both req continuously → CPU granted cycles 0–3, debug granted cycle 4, CPU cycles 5–8, debug cycle 9.
- Locked burst: debug writes 32'h1,32'h2,32'h3 to 9'h020–9'h022 with `dbg_lock`=1, CPU requesting → `cpu_gnt`=0 and `locked`=1 throughout; lock dropped on third write → CPU granted the following cycle; readback returns 1,2,3.
- Write isolation: CPU write 32'hA5A5A5A5 to 9'h030 → `mem_we`=1 one cycle, no rvalid on either port; idle cycle → `mem_we`=0, `mem_addr`=0.
- Reset mid-operation: debug read granted, `rst` pulsed low before next edge → `dbg_rvalid` stays 0; state ARB, `locked`=0 after release.
